// File: rtl/loop_lock_ctrl_pkg.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : loop_ctrl_pkg
// Brief   : Shared types, default widths and helpers for the loop lock sequencer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
package loop_ctrl_pkg;

  localparam int C_ERR_W_DEF  = 32;
  localparam int C_CNT_W_DEF  = 16;
  localparam int C_GAIN_W_DEF = 4;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SETTLE = 3'd1,
    ST_ACQ    = 3'd2,
    ST_TRACK  = 3'd3,
    ST_FAULT  = 3'd4
  } state_t;

  // Most-negative input has no positive twin, so it clamps to the largest magnitude.
  function automatic logic [31:0] abs_sat(input logic signed [31:0] x);
    if (x == 32'sh8000_0000)
      return 32'h7FFF_FFFF;
    else if (x < 0)
      return 32'(-x);
    else
      return 32'(x);
  endfunction

endpackage
`default_nettype wire

// File: rtl/loop_lock_ctrl_if.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : loop_lock_ctrl_if
// Brief   : Error stream, CPU varset and status bundle of the loop sequencer.
//           Optional LOOP_ACQ_TIMEOUT_EN adds the timeout/fault pair.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
interface loop_lock_ctrl_if #(
  parameter int ERR_W  = 32,
  parameter int CNT_W  = 16,
  parameter int GAIN_W = 4
);
  logic                     i_enable;
  logic                     i_err_valid;
  logic signed [ERR_W-1:0]  i_err;
  logic [31:0]              i_err_th;
  logic [31:0]              i_settle_cnt;
  logic [CNT_W-1:0]         i_lock_cnt;
  logic [CNT_W-1:0]         i_unlock_cnt;
  logic [GAIN_W-1:0]        i_gain_acq;
  logic [GAIN_W-1:0]        i_gain_trk;
`ifdef LOOP_ACQ_TIMEOUT_EN
  logic [31:0]              i_acq_timeout;
  logic                     o_fault;
`endif
  logic                     o_fb_on;
  logic [GAIN_W-1:0]        o_gain_sel;
  logic                     o_locked;
  logic [2:0]               o_state;
  logic [15:0]              o_relock_cnt;
  logic                     o_gain_chg;

  modport master (
    output i_enable, i_err_valid, i_err, i_err_th, i_settle_cnt,
           i_lock_cnt, i_unlock_cnt, i_gain_acq, i_gain_trk,
`ifdef LOOP_ACQ_TIMEOUT_EN
    output i_acq_timeout,
    input  o_fault,
`endif
    input  o_fb_on, o_gain_sel, o_locked, o_state, o_relock_cnt, o_gain_chg
  );

  modport slave (
    input  i_enable, i_err_valid, i_err, i_err_th, i_settle_cnt,
           i_lock_cnt, i_unlock_cnt, i_gain_acq, i_gain_trk,
`ifdef LOOP_ACQ_TIMEOUT_EN
    input  i_acq_timeout,
    output o_fault,
`endif
    output o_fb_on, o_gain_sel, o_locked, o_state, o_relock_cnt, o_gain_chg
  );
endinterface
`default_nettype wire

// File: rtl/loop_lock_ctrl_run_counter.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : loop_run_counter
// Brief   : Saturating consecutive-event counter with reached-target flag.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module loop_run_counter #(
  parameter int CNT_W = 16
) (
  input  wire              i_clk,
  input  wire              i_rst_n,
  input  wire              i_inc,
  input  wire              i_clr,
  input  wire [CNT_W-1:0]  i_target,
  output logic             o_reached
);
  logic [CNT_W-1:0] r_count;
  logic [CNT_W-1:0] w_count_inc;
  logic [CNT_W-1:0] w_target_eff;

  assign w_count_inc  = (&r_count) ? r_count : r_count + CNT_W'(1);
  assign w_target_eff = (i_target == '0) ? CNT_W'(1) : i_target;
  // Flags the event that completes the run, so the caller can act on the same edge.
  assign o_reached    = i_inc && (w_count_inc >= w_target_eff);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)
      r_count <= '0;
    else if (i_clr)
      r_count <= '0;
    else if (i_inc)
      r_count <= w_count_inc;
  end
endmodule
`default_nettype wire

// File: rtl/loop_lock_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : loop_lock_ctrl
// Brief   : FOG loop sequencer: settle, acquire at high gain, track at low gain.
//           Optional LOOP_ACQ_TIMEOUT_EN adds an ACQ dwell timeout into FAULT.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module loop_lock_ctrl
  import loop_ctrl_pkg::*;
#(
  parameter int ERR_W  = C_ERR_W_DEF,
  parameter int CNT_W  = C_CNT_W_DEF,
  parameter int GAIN_W = C_GAIN_W_DEF
) (
  input  wire              i_clk,
  input  wire              i_rst_n,
  loop_lock_ctrl_if.slave  bus
);
  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_smp_valid;
  logic                    r_smp_inband;
  logic [31:0]             r_settle_cnt;
  logic [32:0]             w_settle_inc;
  logic [32:0]             w_settle_tgt;
  logic                    w_settle_done;
  logic                    w_lock_hit;
  logic                    w_unlock_hit;
  logic                    w_in_acq;
  logic                    w_in_trk;
  logic                    w_smp_in;
  logic                    w_smp_out;
  logic signed [ERR_W-1:0] w_err;
  logic [31:0]             w_err_mag;
  logic [GAIN_W-1:0]       w_gain_nxt;
  logic [GAIN_W-1:0]       r_gain_sel;
  logic                    r_fb_on;
  logic                    r_locked;
  logic                    r_gain_chg;
  logic [15:0]             r_relock_cnt;

  assign w_err     = bus.i_err;
  assign w_err_mag = abs_sat(32'(w_err));
  assign w_in_acq  = (r_state == ST_ACQ);
  assign w_in_trk  = (r_state == ST_TRACK);
  assign w_smp_in  = r_smp_valid && r_smp_inband;
  assign w_smp_out = r_smp_valid && !r_smp_inband;

  // Band decision is registered; the FSM acts on it one clock after the strobe.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_smp_valid  <= 1'b0;
      r_smp_inband <= 1'b0;
    end else begin
      r_smp_valid  <= bus.i_err_valid && bus.i_enable && (w_in_acq || w_in_trk);
      r_smp_inband <= (w_err_mag <= bus.i_err_th);
    end
  end

  loop_run_counter #(.CNT_W(CNT_W)) u_run_inband (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_inc     (w_in_acq && w_smp_in),
    .i_clr     (!bus.i_enable || !w_in_acq || w_smp_out || w_lock_hit),
    .i_target  (bus.i_lock_cnt),
    .o_reached (w_lock_hit)
  );

  loop_run_counter #(.CNT_W(CNT_W)) u_run_outband (
    .i_clk     (i_clk),
    .i_rst_n   (i_rst_n),
    .i_inc     (w_in_trk && w_smp_out),
    .i_clr     (!bus.i_enable || !w_in_trk || w_smp_in || w_unlock_hit),
    .i_target  (bus.i_unlock_cnt),
    .o_reached (w_unlock_hit)
  );

  assign w_settle_inc  = {1'b0, r_settle_cnt} + 33'd1;
  assign w_settle_tgt  = (bus.i_settle_cnt == '0) ? 33'd1 : {1'b0, bus.i_settle_cnt};
  assign w_settle_done = (w_settle_inc >= w_settle_tgt);

`ifdef LOOP_ACQ_TIMEOUT_EN
  logic [31:0] r_acq_dwell;
  logic        w_acq_expired;
  logic        r_fault;

  assign w_acq_expired = (bus.i_acq_timeout != '0) &&
                         (({1'b0, r_acq_dwell} + 33'd1) >= {1'b0, bus.i_acq_timeout});
  assign bus.o_fault   = r_fault;
`endif

  always_comb begin
    w_state_nxt = r_state;
    if (!bus.i_enable) begin
      w_state_nxt = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE:   w_state_nxt = ST_SETTLE;
        ST_SETTLE: if (w_settle_done) w_state_nxt = ST_ACQ;
        ST_ACQ: begin
          if (w_lock_hit) w_state_nxt = ST_TRACK;
`ifdef LOOP_ACQ_TIMEOUT_EN
          else if (w_acq_expired) w_state_nxt = ST_FAULT;
`endif
        end
        ST_TRACK:  if (w_unlock_hit) w_state_nxt = ST_ACQ;
`ifdef LOOP_ACQ_TIMEOUT_EN
        ST_FAULT:  w_state_nxt = ST_FAULT;
`endif
        default:   w_state_nxt = ST_IDLE;
      endcase
    end
  end

  assign w_gain_nxt = (w_state_nxt == ST_TRACK) ? bus.i_gain_trk : bus.i_gain_acq;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state      <= ST_IDLE;
      r_settle_cnt <= '0;
      r_relock_cnt <= '0;
      r_fb_on      <= 1'b0;
      r_locked     <= 1'b0;
      r_gain_sel   <= '0;
      r_gain_chg   <= 1'b0;
`ifdef LOOP_ACQ_TIMEOUT_EN
      r_acq_dwell  <= '0;
      r_fault      <= 1'b0;
`endif
    end else begin
      r_state      <= w_state_nxt;
      r_settle_cnt <= (r_state == ST_SETTLE && w_state_nxt == ST_SETTLE) ? w_settle_inc[31:0] : '0;
      if (w_in_trk && w_state_nxt == ST_ACQ && !(&r_relock_cnt))
        r_relock_cnt <= r_relock_cnt + 16'd1;
      r_fb_on      <= (w_state_nxt == ST_ACQ) || (w_state_nxt == ST_TRACK);
      r_locked     <= (w_state_nxt == ST_TRACK);
      r_gain_sel   <= w_gain_nxt;
      r_gain_chg   <= (w_gain_nxt != r_gain_sel) && (w_state_nxt != ST_IDLE);
`ifdef LOOP_ACQ_TIMEOUT_EN
      if (w_in_acq && w_state_nxt == ST_ACQ)
        r_acq_dwell <= (&r_acq_dwell) ? r_acq_dwell : r_acq_dwell + 32'd1;
      else
        r_acq_dwell <= '0;
      r_fault      <= (w_state_nxt == ST_FAULT);
`endif
    end
  end

  assign bus.o_state      = r_state;
  assign bus.o_fb_on      = r_fb_on;
  assign bus.o_locked     = r_locked;
  assign bus.o_gain_sel   = r_gain_sel;
  assign bus.o_gain_chg   = r_gain_chg;
  assign bus.o_relock_cnt = r_relock_cnt;
endmodule
`default_nettype wire

// File: tb/tb_loop_lock_ctrl.sv
`default_nettype none
//------------------------------------------------------------------------------
// Module  : tb_loop_lock_ctrl
// Brief   : Directed plus randomized bench for loop_lock_ctrl against a reference model.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
module tb_loop_lock_ctrl;
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  loop_lock_ctrl_if #(.ERR_W(32), .CNT_W(16), .GAIN_W(4)) bus ();

  loop_lock_ctrl #(.ERR_W(32), .CNT_W(16), .GAIN_W(4)) dut (
    .i_clk   (clk),
    .i_rst_n (rst_n),
    .bus     (bus)
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s observed=%0d expected=%0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: integer state number plus plain run/clock counts.
  int     m_st, m_run_in, m_run_out, m_relock, m_gain;
  longint m_settle_clks;
  bit     m_fb, m_locked, m_chg;
  bit     pend[$];

  function automatic longint at_least_one(input longint x);
    return (x == 0) ? 1 : x;
  endfunction

  function automatic bit in_band(input logic [31:0] err, input logic [31:0] th);
    longint v;
    v = longint'($signed(err));
    if (v < 0) v = -v;
    if (v > 64'sh7FFF_FFFF) v = 64'sh7FFF_FFFF;
    return v <= longint'({32'd0, th});
  endfunction

  task automatic model_reset();
    m_st = 0; m_run_in = 0; m_run_out = 0; m_relock = 0; m_gain = 0;
    m_settle_clks = 0; m_fb = 0; m_locked = 0; m_chg = 0;
    pend.delete();
  endtask

  // Predicts the outputs after the coming rising edge from the inputs now applied.
  task automatic model_edge();
    bit have, smp_in;
    int nxt, gain_nxt;
    have = 0; smp_in = 0;
    if (pend.size() > 0) begin have = 1; smp_in = pend.pop_front(); end
    if (bus.i_enable && bus.i_err_valid && (m_st == 2 || m_st == 3))
      pend.push_back(in_band(bus.i_err, bus.i_err_th));
    nxt = m_st;
    if (!bus.i_enable) nxt = 0;
    else case (m_st)
      0: begin nxt = 1; m_settle_clks = 0; end
      1: begin
        m_settle_clks++;
        if (m_settle_clks >= at_least_one(longint'(bus.i_settle_cnt))) nxt = 2;
      end
      2: if (have) begin
        if (smp_in) begin
          if (m_run_in < 65535) m_run_in++;
          if (m_run_in >= at_least_one(longint'(bus.i_lock_cnt))) nxt = 3;
        end else m_run_in = 0;
      end
      3: if (have) begin
        if (!smp_in) begin
          if (m_run_out < 65535) m_run_out++;
          if (m_run_out >= at_least_one(longint'(bus.i_unlock_cnt))) begin
            nxt = 2;
            if (m_relock < 65535) m_relock++;
          end
        end else m_run_out = 0;
      end
      default: nxt = 0;
    endcase
    if (nxt != m_st) begin m_run_in = 0; m_run_out = 0; end
    gain_nxt = (nxt == 3) ? int'(bus.i_gain_trk) : int'(bus.i_gain_acq);
    m_chg    = (gain_nxt != m_gain) && (nxt != 0);
    m_gain   = gain_nxt;
    m_fb     = (nxt == 2) || (nxt == 3);
    m_locked = (nxt == 3);
    m_st     = nxt;
  endtask

  task automatic check_outputs();
    check("state",    64'(bus.o_state),      64'(m_st));
    check("fb_on",    64'(bus.o_fb_on),      64'(m_fb));
    check("gain_sel", 64'(bus.o_gain_sel),   64'(m_gain));
    check("locked",   64'(bus.o_locked),     64'(m_locked));
    check("relock",   64'(bus.o_relock_cnt), 64'(m_relock));
    check("gain_chg", 64'(bus.o_gain_chg),   64'(m_chg));
  endtask

  task automatic step(input bit vld, input logic [31:0] err);
    bus.i_err_valid = vld;
    bus.i_err       = err;
    model_edge();
    @(negedge clk);
    check_outputs();
  endtask

  int settle_seen;
  int chg_seen;
  int seq3[7] = '{50, -99, 200, 10, 20, -100, 0};
  int seq4[6] = '{150, -150, 50, 150, 150, 150};

  initial begin
    bus.i_enable     = 1'b0;
    bus.i_err_valid  = 1'b0;
    bus.i_err        = '0;
    bus.i_err_th     = 32'd100;
    bus.i_settle_cnt = 32'd10;
    bus.i_lock_cnt   = 16'd4;
    bus.i_unlock_cnt = 16'd3;
    bus.i_gain_acq   = 4'd5;
    bus.i_gain_trk   = 4'd2;
`ifdef LOOP_ACQ_TIMEOUT_EN
    bus.i_acq_timeout = 32'd0;
`endif
    model_reset();
    repeat (2) @(negedge clk);
    check_outputs();
    rst_n = 1'b1;
    step(1'b0, 32'd0);

    // Settle length, with strobes that must be ignored
    bus.i_enable = 1'b1;
    settle_seen  = 0;
    for (int i = 0; i < 14; i++) begin
      step((i % 3 == 0) && (i < 10), 32'd5);
      if (bus.o_state == 3'd1) settle_seen++;
    end
    check("settle_len", 64'(settle_seen), 64'd10);
    check("fb_on_acq",  64'(bus.o_fb_on), 64'd1);

    // Acquire: run broken by 200, lock after the fourth in-band sample
    chg_seen = 0;
    for (int i = 0; i < 7; i++) begin
      step(1'b1, 32'(seq3[i]));
      if (bus.o_gain_chg) chg_seen++;
      step(1'b0, 32'd0);
      if (bus.o_gain_chg) chg_seen++;
      if (i == 5) check("acq_not_yet", 64'(bus.o_state), 64'd2);
    end
    check("lock_state", 64'(bus.o_state),    64'd3);
    check("lock_gain",  64'(bus.o_gain_sel), 64'd2);
    check("chg_pulses", 64'(chg_seen),       64'd1);

    // Track: loss of lock after three consecutive out-of-band samples
    for (int i = 0; i < 6; i++) begin
      step(1'b1, 32'(seq4[i]));
      step(1'b0, 32'd0);
    end
    check("unlock_state", 64'(bus.o_state),      64'd2);
    check("unlock_cnt",   64'(bus.o_relock_cnt), 64'd1);
    check("unlock_lock",  64'(bus.o_locked),     64'd0);

    // Most-negative error against wide and narrow thresholds
    bus.i_lock_cnt   = 16'd1;
    bus.i_unlock_cnt = 16'd1;
    bus.i_err_th     = 32'hFFFF_FFFE;
    step(1'b1, 32'h8000_0000);
    step(1'b0, 32'd0);
    check("minneg_inband", 64'(bus.o_state), 64'd3);
    bus.i_err_th     = 32'h7FFF_FFFE;
    step(1'b1, 32'h8000_0000);
    step(1'b0, 32'd0);
    check("minneg_outband", 64'(bus.o_state), 64'd2);

    // Asynchronous reset while tracking
    bus.i_err_th = 32'd100;
    step(1'b1, 32'd0);
    step(1'b0, 32'd0);
    check("pre_reset_trk", 64'(bus.o_state), 64'd3);
    #3 rst_n = 1'b0;
    #1;
    check("rst_state",  64'(bus.o_state),      64'd0);
    check("rst_fb_on",  64'(bus.o_fb_on),      64'd0);
    check("rst_gain",   64'(bus.o_gain_sel),   64'd0);
    check("rst_locked", 64'(bus.o_locked),     64'd0);
    check("rst_relock", 64'(bus.o_relock_cnt), 64'd0);
    check("rst_chg",    64'(bus.o_gain_chg),   64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    check_outputs();

    // Randomized operation with occasional enable drops and CPU rewrites
    bus.i_settle_cnt = 32'($urandom_range(3));
    bus.i_lock_cnt   = 16'($urandom_range(4));
    bus.i_unlock_cnt = 16'($urandom_range(4));
    bus.i_err_th     = 32'($urandom_range(200));
    for (int i = 0; i < 3000; i++) begin
      int e;
      bus.i_enable = ($urandom_range(199) != 0);
      if ($urandom_range(99) == 0) begin
        bus.i_lock_cnt   = 16'($urandom_range(4));
        bus.i_unlock_cnt = 16'($urandom_range(4));
        bus.i_err_th     = 32'($urandom_range(200));
        bus.i_settle_cnt = 32'($urandom_range(3));
        bus.i_gain_acq   = 4'($urandom_range(15));
        bus.i_gain_trk   = 4'($urandom_range(15));
      end
      if ($urandom_range(9) == 0)
        e = int'($urandom);
      else
        e = int'($urandom_range(2 * int'(bus.i_err_th) + 40)) - (int'(bus.i_err_th) + 20);
      step($urandom_range(4) < 2, 32'(e));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
`default_nettype wire
